// File: rtl/serial_mag_compare_ctrl_if.sv
// Start/result bundle for the serial magnitude comparator: operand handshake
// toward the controller, sticky compare result and slice count back.
interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int NSLICE = WIDTH / 2;
    localparam int SW     = $clog2(NSLICE) + 1;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             smaller;
    logic             equal;
    logic [SW-1:0]    slices;

    modport master (
        output start_valid, a, b,
        input  start_ready, busy, done, greater, smaller, equal, slices
    );

    modport slave (
        input  start_valid, a, b,
        output start_ready, busy, done, greater, smaller, equal, slices
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned magnitude compare: one 2-bit comparator slice is stepped
// MSB-first over the latched operands; the first unequal slice decides.
module serial_mag_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_mag_compare_ctrl_if.slave  bus
);
    localparam int NSLICE = WIDTH / 2;
    localparam int SW     = $clog2(NSLICE) + 1;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    cnt_q;
    logic             flag_g_q;
    logic             flag_s_q;

    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             slice_gt;
    logic             slice_lt;
    logic             slice_ne;
    logic             nxt_g;
    logic             nxt_s;
    logic [SW-1:0]    cnt_nxt;
    logic             run_exit;

    // Shared 2-bit comparator slice, returns {gt, lt}.
    function automatic logic [1:0] cmp2(input logic [1:0] x, input logic [1:0] y);
        logic gt;
        logic lt;
        gt = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
        lt = (~x[1] & y[1]) | (~(x[1] ^ y[1]) & ~x[0] & y[0]);
        return {gt, lt};
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                sa = a_q[2*i +: 2];
                sb = b_q[2*i +: 2];
            end
        end
    end

    assign {slice_gt, slice_lt} = cmp2(sa, sb);
    assign slice_ne = slice_gt | slice_lt;

    // The first difference is sticky; later slices only matter while none was seen.
    assign nxt_g    = flag_g_q | (~(flag_g_q | flag_s_q) & slice_gt);
    assign nxt_s    = flag_s_q | (~(flag_g_q | flag_s_q) & slice_lt);
    assign cnt_nxt  = cnt_q + SW'(1);
    assign run_exit = (slice_ne & EARLY_EXIT) | (idx_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the operand registers are plain flops, not a memory, so they are
    // reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            flag_g_q        <= 1'b0;
            flag_s_q        <= 1'b0;
            bus.start_ready <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.greater     <= 1'b0;
            bus.smaller     <= 1'b0;
            bus.equal       <= 1'b0;
            bus.slices      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid && bus.start_ready) begin
                        a_q             <= bus.a;
                        b_q             <= bus.b;
                        idx_q           <= IW'(NSLICE - 1);
                        cnt_q           <= '0;
                        flag_g_q        <= 1'b0;
                        flag_s_q        <= 1'b0;
                        bus.greater     <= 1'b0;
                        bus.smaller     <= 1'b0;
                        bus.equal       <= 1'b0;
                        bus.slices      <= '0;
                        bus.start_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                        state_q         <= RUN;
                    end
                end
                RUN: begin
                    flag_g_q <= nxt_g;
                    flag_s_q <= nxt_s;
                    cnt_q    <= cnt_nxt;
                    if (run_exit) begin
                        bus.greater <= nxt_g;
                        bus.smaller <= nxt_s;
                        bus.equal   <= ~(nxt_g | nxt_s);
                        bus.slices  <= cnt_nxt;
                        bus.done    <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                DONE: begin
                    bus.done        <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.start_ready <= 1'b1;
                    state_q         <= IDLE;
                end
                default: begin
                    bus.done        <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.start_ready <= 1'b1;
                    state_q         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl: four instances (WIDTH 8/6, EARLY_EXIT 1/0)
// share one operand stream; a directed table, corner sequences and a sweep.
module tb_serial_mag_compare_ctrl;
    logic       clk;
    logic       rst_n;
    logic       sv;
    logic [7:0] av;
    logic [7:0] bv;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    serial_mag_compare_ctrl_if #(.WIDTH(8)) i0 ();
    serial_mag_compare_ctrl_if #(.WIDTH(8)) i1 ();
    serial_mag_compare_ctrl_if #(.WIDTH(6)) i2 ();
    serial_mag_compare_ctrl_if #(.WIDTH(6)) i3 ();

    assign i0.start_valid = sv;  assign i0.a = av;       assign i0.b = bv;
    assign i1.start_valid = sv;  assign i1.a = av;       assign i1.b = bv;
    assign i2.start_valid = sv;  assign i2.a = av[5:0];  assign i2.b = bv[5:0];
    assign i3.start_valid = sv;  assign i3.a = av[5:0];  assign i3.b = bv[5:0];

    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    serial_mag_compare_ctrl #(.WIDTH(6), .EARLY_EXIT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
    serial_mag_compare_ctrl #(.WIDTH(6), .EARLY_EXIT(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));

    logic       done_w [4];
    logic       g_w    [4];
    logic       s_w    [4];
    logic       e_w    [4];
    logic       rdy_w  [4];
    logic       busy_w [4];
    logic [2:0] sl_w   [4];

    assign done_w[0] = i0.done;  assign g_w[0] = i0.greater;  assign s_w[0] = i0.smaller;
    assign done_w[1] = i1.done;  assign g_w[1] = i1.greater;  assign s_w[1] = i1.smaller;
    assign done_w[2] = i2.done;  assign g_w[2] = i2.greater;  assign s_w[2] = i2.smaller;
    assign done_w[3] = i3.done;  assign g_w[3] = i3.greater;  assign s_w[3] = i3.smaller;
    assign e_w[0] = i0.equal;    assign rdy_w[0] = i0.start_ready;  assign busy_w[0] = i0.busy;
    assign e_w[1] = i1.equal;    assign rdy_w[1] = i1.start_ready;  assign busy_w[1] = i1.busy;
    assign e_w[2] = i2.equal;    assign rdy_w[2] = i2.start_ready;  assign busy_w[2] = i2.busy;
    assign e_w[3] = i3.equal;    assign rdy_w[3] = i3.start_ready;  assign busy_w[3] = i3.busy;
    assign sl_w[0] = i0.slices;  assign sl_w[1] = i1.slices;
    assign sl_w[2] = i2.slices;  assign sl_w[3] = i3.slices;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         g;
        bit         s;
        bit         e;
        int         sl_early;
        int         sl_full;
        int         mode;     // 0 plain, 1 start_valid pulse mid-RUN, 2 scramble a/b
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        tot_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int wid_of(input int i);
        return (i < 2) ? 8 : 6;
    endfunction

    function automatic bit early_of(input int i);
        return (i % 2) == 0;
    endfunction

    // Reference slice count: position of first differing slice from the MSB.
    function automatic int model_slices(input int i, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = wid_of(i) / 2;
        if (!early_of(i)) return n;
        for (int s = n - 1; s >= 0; s--) begin
            if (a[2*s +: 2] != b[2*s +: 2]) return n - s;
        end
        return n;
    endfunction

    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input bit use_tbl,
                           input vec_t v, input int mode);
        int         got_cyc [4];
        bit         rg [4];
        bit         rs [4];
        bit         re [4];
        int         rsl [4];
        bit         clean [4];
        bit         all;
        logic [7:0] ma;
        logic [7:0] mb;
        int         eg;
        int         es;
        int         ee;
        int         esl;
        @(negedge clk);
        sv = 1'b1; av = a; bv = b;
        @(negedge clk);
        sv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got_cyc[i] = 0; clean[i] = 1'b1;
            rg[i] = 0; rs[i] = 0; re[i] = 0; rsl[i] = 0;
        end
        all = 1'b0;
        for (int n = 1; n <= 12 && !all; n++) begin
            all = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (got_cyc[i] == 0) begin
                    if (done_w[i]) begin
                        got_cyc[i] = n;
                        rg[i] = g_w[i]; rs[i] = s_w[i]; re[i] = e_w[i];
                        rsl[i] = int'(sl_w[i]);
                        if (rdy_w[i] || !busy_w[i]) clean[i] = 1'b0;
                    end else if (g_w[i] || s_w[i] || e_w[i] || rdy_w[i] || !busy_w[i]) begin
                        clean[i] = 1'b0;
                    end
                end
                if (got_cyc[i] == 0) all = 1'b0;
            end
            if (mode == 1 && n == 2) begin sv = 1'b1; av = 8'hFF; bv = 8'h00; end
            if (mode == 1 && n == 3) sv = 1'b0;
            if (mode == 2) begin av = 8'($urandom); bv = 8'($urandom); end
            if (!all) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            ma = (wid_of(i) == 8) ? a : {2'b00, a[5:0]};
            mb = (wid_of(i) == 8) ? b : {2'b00, b[5:0]};
            if (use_tbl && i < 2) begin
                eg = v.g; es = v.s; ee = v.e;
                esl = early_of(i) ? v.sl_early : v.sl_full;
            end else begin
                eg = int'(ma > mb); es = int'(ma < mb); ee = int'(ma == mb);
                esl = model_slices(i, a, b);
            end
            check($sformatf("u%0d %02h/%02h done_cycle", i, a, b), got_cyc[i], esl + 1);
            check($sformatf("u%0d %02h/%02h greater", i, a, b), int'(rg[i]), eg);
            check($sformatf("u%0d %02h/%02h smaller", i, a, b), int'(rs[i]), es);
            check($sformatf("u%0d %02h/%02h equal", i, a, b), int'(re[i]), ee);
            check($sformatf("u%0d %02h/%02h slices", i, a, b), rsl[i], esl);
            check($sformatf("u%0d %02h/%02h quiet_until_done", i, a, b), int'(clean[i]), 1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s u%0d start_ready", tag, i), int'(rdy_w[i]), 1);
            check($sformatf("%s u%0d busy", tag, i), int'(busy_w[i]), 0);
            check($sformatf("%s u%0d done", tag, i), int'(done_w[i]), 0);
            check($sformatf("%s u%0d flags", tag, i), int'({g_w[i], s_w[i], e_w[i]}), 0);
            check($sformatf("%s u%0d slices", tag, i), int'(sl_w[i]), 0);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 20 && !idle; n++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int i = 0; i < 4; i++) if (!rdy_w[i] || busy_w[i]) idle = 1'b0;
        end
        check("drain all idle", int'(idle), 1);
    endtask

    initial begin
        vec_t dummy;
        bit   saw_done;
        int   n_done;
        dummy = '{a: 8'h00, b: 8'h00, g: 0, s: 0, e: 0, sl_early: 0, sl_full: 0, mode: 0};
        //          a      b      g  s  e  slE slF mode
        vecs[0]  = '{8'hC0, 8'h40, 1, 0, 0, 1,  4,  0};
        vecs[1]  = '{8'h5A, 8'h5A, 0, 0, 1, 4,  4,  1};
        vecs[2]  = '{8'h12, 8'h13, 0, 1, 0, 4,  4,  0};
        vecs[3]  = '{8'h80, 8'h7F, 1, 0, 0, 1,  4,  0};
        vecs[4]  = '{8'h01, 8'h02, 0, 1, 0, 4,  4,  2};
        vecs[5]  = '{8'h00, 8'h00, 0, 0, 1, 4,  4,  0};
        vecs[6]  = '{8'hFF, 8'h00, 1, 0, 0, 1,  4,  0};
        vecs[7]  = '{8'h3C, 8'h3D, 0, 1, 0, 4,  4,  0};
        vecs[8]  = '{8'hA5, 8'h95, 1, 0, 0, 2,  4,  0};
        vecs[9]  = '{8'h40, 8'hC0, 0, 1, 0, 1,  4,  0};
        vecs[10] = '{8'h0C, 8'h08, 1, 0, 0, 3,  4,  0};
        vecs[11] = '{8'hFF, 8'hFF, 0, 0, 1, 4,  4,  0};

        rst_n = 1'b0; sv = 1'b0; av = '0; bv = '0;
        #23;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) run_cmp(vecs[k].a, vecs[k].b, 1'b1, vecs[k], vecs[k].mode);

        // start_valid held through the first compare: re-accept right after DONE.
        drain();
        sv = 1'b1; av = 8'h01; bv = 8'h02;
        @(negedge clk);
        av = 8'hC0; bv = 8'h40;
        saw_done = 1'b0;
        for (int n = 1; n <= 10 && !saw_done; n++) begin
            if (done_w[0]) saw_done = 1'b1;
            else @(negedge clk);
        end
        check("held u0 first done", int'(saw_done), 1);
        check("held u0 first smaller", int'(s_w[0]), 1);
        @(negedge clk);
        check("held u0 idle after done", int'(rdy_w[0]), 1);
        check("held u0 result kept in idle", int'(s_w[0]), 1);
        @(negedge clk);
        sv = 1'b0;
        check("held u0 accepted ready", int'(rdy_w[0]), 0);
        check("held u0 accepted busy", int'(busy_w[0]), 1);
        check("held u0 results cleared", int'({g_w[0], s_w[0], e_w[0]}), 0);
        check("held u0 slices cleared", int'(sl_w[0]), 0);
        @(negedge clk);
        check("held u0 second done", int'(done_w[0]), 1);
        check("held u0 second greater", int'(g_w[0]), 1);
        check("held u0 second slices", int'(sl_w[0]), 1);
        drain();

        // Asynchronous reset in the middle of RUN.
        sv = 1'b1; av = 8'h5A; bv = 8'h5A;
        @(negedge clk);
        sv = 1'b0;
        @(negedge clk);
        check("pre-reset u1 busy", int'(busy_w[1]), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async");
        n_done = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_w[i]) n_done++;
        end
        check("no done during reset", n_done, 0);
        rst_n = 1'b1;
        run_cmp(8'hC0, 8'h40, 1'b1, vecs[0], 0);

        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (k % 4 == 0) ? ra ^ 8'(1 << $urandom_range(7, 0)) : 8'($urandom);
            if (k % 7 == 0) rb = ra;
            run_cmp(ra, rb, 1'b0, dummy, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
